booth_capture_mult: RTL and testbench
=====================================

Name: booth_capture_mult

Overview:
- Sits directly downstream of the pushbutton press counter.
- Consumes its 4-bit `count` and `valid` outputs and captures two successive counts as signed two's-complement operands A (multiplicand) and B (multiplier).
- Multiplies them with a sequential radix-2 Booth algorithm, one iteration per clock.
- Presents the 2*WIDTH-bit signed product with a one-cycle `done` pulse, ready for display logic.

Parameters:
- WIDTH, 4, operand width in bits; must equal the pushbutton `count` width.
- ITER_W, 3, width of the iteration counter; must satisfy 2^ITER_W > WIDTH.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- count  in  WIDTH  operand value from the pushbutton stage, read as signed two's complement.
- valid  in  1  pushbutton "count final" flag; level or pulse.
- operand_a  out  WIDTH  captured multiplicand.
- operand_b  out  WIDTH  captured multiplier.
- result  out  2*WIDTH  signed product of the last completed multiplication.
- done  out  1  one-cycle pulse when `result` updates.
- busy  out  1  high while in CALC.
- wait_b  out  1  high while A is held and B is awaited.

Behaviour:
- Reset (synchronous, active-high, `rst` sampled high at an edge):
  - state <= IDLE; operand_a, operand_b, result <= 0; done, busy, wait_b <= 0.
  - Internal registers cleared, including `valid_d`, which is cleared to 0.
  - Reset overrides any state, including mid-CALC; a partial product is never written to `result`.
- Capture event:
  - `vrise` = valid & ~valid_d; `valid_d` is a registered copy of `valid`.
  - A `valid` held high for many cycles yields exactly one capture.
- States:
  - IDLE:
    - On vrise: operand_a <= count; wait_b <= 1; go to WAIT_B.
  - WAIT_B:
    - On vrise: operand_b <= count.
    - Load the datapath: acc (WIDTH+1 bits) <= 0; q <= count; q_m1 <= 0; m <= sign-extend(operand_a) to WIDTH+1; iter <= 0.
    - Set wait_b <= 0 and busy <= 1; go to CALC.
  - CALC (one Booth step per cycle):
    - On {q[0], q_m1}: 01 → acc + m; 10 → acc - m; 00 or 11 → acc unchanged.
    - Then shift {acc, q, q_m1} arithmetically right by 1, replicating the acc MSB.
    - iter <= iter + 1. The step with iter == WIDTH-1 is the last; then go to DONE.
    - vrise in CALC is ignored; it is not queued.
  - DONE:
    - result <= {acc[WIDTH-1:0], q}; done <= 1 for this single cycle; busy <= 0; go to IDLE.
    - vrise in DONE is ignored.
- Latency: if B is captured at edge k, `result` and `done` are valid after edge k+WIDTH+1 (edge k+5 for WIDTH=4).
- Width rule:
  - The acc guard bit (WIDTH+1 bits) makes the most-negative multiplicand (-8 for WIDTH=4) correct.
  - The product always fits in 2*WIDTH signed bits (range -56..64 for WIDTH=4).
- `result` holds its value until the next DONE.
- `operand_a` and `operand_b` hold their values until overwritten.
- `valid_d` updates every cycle regardless of state.
  - Consequence: a `valid` that rises during CALC and is still high in IDLE produces no capture.

Decomposition:
- Package booth_pkg holds:
  - The state encoding: IDLE=2'd0, WAIT_B=2'd1, CALC=2'd2, DONE=2'd3.
  - The default WIDTH constant.
- One sub-module, booth_step: purely combinational, WIDTH+1-bit acc.
  - Inputs: acc, q, q_m1, m.
  - Outputs: next acc, next q, next q_m1.
  - Performs the add/subtract and the arithmetic shift.
- The top level holds the edge detect, FSM, iteration counter and output registers.

Test Plan:
- Reset, then valid pulse with count=3, then valid pulse with count=5 → wait_b high between the captures; busy high for 4 cycles; done pulses once at B-edge+5; result=8'h0F (15).
- A=4'hD (-3), B=4'h5 → result=8'hF1 (-15). A=4'h7, B=4'h8 (-8) → result=8'hC8 (-56).
- A=4'h8, B=4'h8 (both -8) → result=8'h40 (64), which checks the guard bit.
- Hold valid high for 10 cycles with count=2 → only operand_a captured, state stays WAIT_B. Then drop valid and pulse it with count=6 → result=8'h0C.
- Pulse valid during CALC → ignored; result matches the original operands; a new capture is accepted only after done.
- Assert rst for one cycle in the second CALC iteration → next cycle all outputs 0, state IDLE, no done pulse. A subsequent 2*3 sequence yields result=8'h06.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth capture multiplier.
//   state_t   : FSM state encoding (IDLE, WAIT_B, CALC, DONE)
//   WIDTH_DEF : default operand width, matching the pushbutton count width
package booth_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   acc    : WIDTH+1-bit accumulator (extra guard bit keeps -2^(W-1) multiplicands exact)
//   q      : multiplier / low product bits
//   q_m1   : bit shifted out of q on the previous step
//   m      : sign-extended multiplicand
//   *_n    : values after add/subtract and the arithmetic right shift
module booth_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] q_n,
  output logic             q_m1_n
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift of {sum, q, q_m1}: sum's MSB is replicated, q_m1 falls off the end.
  assign {acc_n, q_n, q_m1_n} = {sum[WIDTH], sum, q};

endmodule

// File: rtl/booth_capture_mult.sv
// Captures two successive pushbutton counts (rising edges of valid) as signed
// operands A and B, multiplies them with a sequential radix-2 Booth loop
// (one step per clock) and presents the 2*WIDTH-bit signed product.
//   CLK, rst   : clock, synchronous active-high reset
//   count      : operand value from the pushbutton stage (signed)
//   valid      : "count final" flag, level or pulse; only its rising edge captures
//   operand_a  : captured multiplicand
//   operand_b  : captured multiplier
//   result     : product of the last completed multiplication
//   done       : one-cycle pulse when result updates
//   busy       : high while the Booth loop is iterating
//   wait_b     : high while A is held and B is awaited
module booth_capture_mult
  import booth_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ITER_W = 3
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     count,
  input  logic                 valid,
  output logic [WIDTH-1:0]     operand_a,
  output logic [WIDTH-1:0]     operand_b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy,
  output logic                 wait_b
);

  state_t state, next_state;

  logic              valid_d;
  logic              vrise;
  logic [WIDTH:0]    acc, acc_n, m;
  logic [WIDTH-1:0]  q, q_n;
  logic              q_m1, q_m1_n;
  logic [ITER_W-1:0] iter;
  logic              last_iter;

  // valid_d tracks valid every cycle, so a level that rose while we were
  // busy never turns into a late capture.
  assign vrise     = valid & ~valid_d;
  assign last_iter = (iter == ITER_W'(WIDTH-1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .q      (q),
    .q_m1   (q_m1),
    .m      (m),
    .acc_n  (acc_n),
    .q_n    (q_n),
    .q_m1_n (q_m1_n)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (vrise) next_state = WAIT_B;
      WAIT_B:  if (vrise) next_state = CALC;
      CALC:    if (last_iter) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      valid_d   <= 1'b0;
      operand_a <= '0;
      operand_b <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      wait_b    <= 1'b0;
      acc       <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      m         <= '0;
      iter      <= '0;
    end else begin
      state   <= next_state;
      valid_d <= valid;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (vrise) begin
            operand_a <= count;
            wait_b    <= 1'b1;
          end
        end
        WAIT_B: begin
          if (vrise) begin
            operand_b <= count;
            acc       <= '0;
            q         <= count;
            q_m1      <= 1'b0;
            m         <= {operand_a[WIDTH-1], operand_a};
            iter      <= '0;
            wait_b    <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CALC: begin
          acc  <= acc_n;
          q    <= q_n;
          q_m1 <= q_m1_n;
          iter <= iter + 1'b1;
          // Drop busy together with leaving CALC so it tracks the loop exactly.
          if (last_iter) busy <= 1'b0;
        end
        DONE: begin
          result <= {acc[WIDTH-1:0], q};
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_capture_mult.sv
// Self-checking bench for booth_capture_mult: a transaction-level model
// (capture A, capture B, product by plain multiplication, fixed loop length)
// is compared against every DUT output on every cycle, plus directed literal checks.
module tb_booth_capture_mult;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           valid = 1'b0;
  logic [W-1:0]   count = '0;
  logic [W-1:0]   operand_a, operand_b;
  logic [2*W-1:0] result;
  logic           done, busy, wait_b;

  int n_cmp = 0;
  int n_bad = 0;

  booth_capture_mult #(.WIDTH(W), .ITER_W(3)) dut (
    .CLK       (clk),
    .rst       (rst),
    .count     (count),
    .valid     (valid),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .wait_b    (wait_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] prod(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    int ia, ib;
    ia = a;
    ib = b;
    return 8'(ia * ib);
  endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for A, 1 waiting for B, 2 multiplying, 3 delivering
  int           ph = 0;
  int           left = 0;
  logic [W-1:0] ma = '0, mb = '0;
  logic [7:0]   mres = '0, mpend = '0;
  logic         mdone = 0, mbusy = 0, mwait = 0, mpv = 0;

  always @(posedge clk) begin
    logic rise;
    if (rst) begin
      ph = 0; left = 0; ma = '0; mb = '0; mres = '0; mpend = '0;
      mdone = 0; mbusy = 0; mwait = 0; mpv = 0;
    end else begin
      rise = valid && !mpv;
      mpv  = valid;
      mdone = 0;
      case (ph)
        0: if (rise) begin ma = count; mwait = 1; ph = 1; end
        1: if (rise) begin
             mb = count; mpend = prod(ma, count);
             mwait = 0; mbusy = 1; left = W; ph = 2;
           end
        2: begin left--; if (left == 0) begin mbusy = 0; ph = 3; end end
        default: begin mres = mpend; mdone = 1; ph = 0; end
      endcase
    end
    #1;
    chk("operand_a", 8'(operand_a), 8'(ma));
    chk("operand_b", 8'(operand_b), 8'(mb));
    chk("result",    result, mres);
    chk("done",      8'(done),   8'(mdone));
    chk("busy",      8'(busy),   8'(mbusy));
    chk("wait_b",    8'(wait_b), 8'(mwait));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [W-1:0] c);
    @(negedge clk);
    count = c;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Capture B, then wait (bounded) for done; optionally poke valid mid-loop.
  task automatic finish_b(input logic [W-1:0] b, input logic [7:0] exp, input string nm, input int poke_at);
    int  lat, bc;
    bit  seen;
    pulse(b);
    seen = 0; lat = 0; bc = int'(busy);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == poke_at) begin count = 4'h7; valid = 1'b1; end
      else valid = 1'b0;
      if (busy) bc++;
      if (done) begin lat = i; seen = 1; break; end
    end
    valid = 1'b0;
    chk({nm, "_seen"}, 8'(seen), 8'd1);
    chk({nm, "_latency"}, 8'(lat), 8'd5);
    chk({nm, "_busy_cycles"}, 8'(bc), 8'd4);
    chk({nm, "_result"}, result, exp);
  endtask

  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] exp,
                      input string nm, input int poke_at);
    pulse(a);
    idle(2);
    chk({nm, "_wait_b"}, 8'(wait_b), 8'd1);
    chk({nm, "_opa"}, 8'(operand_a), 8'(a));
    finish_b(b, exp, nm, poke_at);
  endtask

  initial begin
    bit seen;
    idle(3);
    chk("rst_result", result, 8'h00);
    chk("rst_done",   8'(done), 8'd0);
    chk("rst_busy",   8'(busy), 8'd0);
    chk("rst_wait_b", 8'(wait_b), 8'd0);
    rst = 1'b0;
    idle(2);

    mult(4'h3, 4'h5, 8'h0F, "m3x5", 0);
    mult(4'hD, 4'h5, 8'hF1, "mn3x5", 0);
    mult(4'h7, 4'h8, 8'hC8, "m7xn8", 0);
    mult(4'h8, 4'h8, 8'h40, "mn8xn8", 0);

    // Held valid: one capture only.
    @(negedge clk);
    count = 4'h2; valid = 1'b1;
    idle(10);
    chk("hold_wait_b", 8'(wait_b), 8'd1);
    chk("hold_opa", 8'(operand_a), 8'h02);
    chk("hold_busy", 8'(busy), 8'd0);
    valid = 1'b0;
    idle(1);
    finish_b(4'h6, 8'h0C, "hold2x6", 0);

    // valid pulse during the Booth loop is dropped.
    mult(4'h3, 4'h5, 8'h0F, "poke3x5", 2);
    idle(1);
    chk("poke_wait_b", 8'(wait_b), 8'd0);
    chk("poke_opa", 8'(operand_a), 8'h03);
    mult(4'h2, 4'h7, 8'h0E, "after_poke", 0);

    // Reset in the second Booth iteration.
    pulse(4'h5);
    idle(1);
    pulse(4'h3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_result", result, 8'h00);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_opa", 8'(operand_a), 8'h00);
    chk("midrst_opb", 8'(operand_b), 8'h00);
    seen = 0;
    repeat (8) begin @(negedge clk); if (done) seen = 1; end
    chk("midrst_no_done", 8'(seen), 8'd0);
    mult(4'h2, 4'h3, 8'h06, "after_rst", 0);

    // Random valid/count traffic with occasional resets.
    repeat (800) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) valid = ~valid;
      count = W'($urandom);
    end
    @(negedge clk);
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Random operand pairs through the full protocol.
    for (int k = 0; k < 20; k++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      mult(a, b, prod(a, b), "rnd", 0);
      idle($urandom_range(0, 3));
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no end expected end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
